// File: rtl/cp0_exc.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc
//  Brief    : MIPS-style CP0 exception/interrupt unit. Holds SR, Cause and
//             EPC, raises a flush/redirect request on a committed exception
//             or enabled interrupt, and serves mfc0/mtc0/eret traffic.
//  Revision : 1.0  initial release
// ============================================================================
module cp0_exc (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] cp0_dout,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] c_ADDR_SR    = 5'd12;
  localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] c_ADDR_EPC   = 5'd14;

  // SR fields
  logic [5:0]  sr_im_q,  sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q,  sr_ie_d;
  // Cause fields
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q, cause_exc_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Request generation; everything is masked while EXL is set, and while
  // Reset is held so no stray request escapes during reset.
  always_comb begin
    int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q & ~Reset;
    exc_req = (exc_code_in != 5'd0) & ~sr_exl_q & ~Reset;
    req     = int_req | exc_req;
  end

  // Architectural views of SR and Cause with unimplemented bits tied to 0.
  always_comb begin
    sr_val           = 32'd0;
    sr_val[15:10]    = sr_im_q;
    sr_val[1]        = sr_exl_q;
    sr_val[0]        = sr_ie_q;
    cause_val        = 32'd0;
    cause_val[31]    = cause_bd_q;
    cause_val[15:10] = cause_ip_q;
    cause_val[6:2]   = cause_exc_q;
  end

  // mfc0 read mux.
  always_comb begin
    cp0_dout = 32'd0;
    case (cp0_addr)
      c_ADDR_SR:    cp0_dout = sr_val;
      c_ADDR_CAUSE: cp0_dout = cause_val;
      c_ADDR_EPC:   cp0_dout = epc_q;
      default:      cp0_dout = 32'd0;
    endcase
  end

  // eret target, forwarding an mtc0 to EPC issued in the same cycle.
  always_comb begin
    if (en && (cp0_addr == c_ADDR_EPC) && !Reset) begin
      epc_out = cp0_din;
    end else begin
      epc_out = epc_q;
    end
  end

  // Next-state: exception entry beats mtc0 and eret; eret beats an mtc0
  // to SR in the same cycle so the return always leaves EXL clear.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_in;
      cause_exc_d = int_req ? 5'd0 : exc_code_in;
      epc_d       = bd_in ? (vpc - 32'd4) : vpc;
    end else begin
      if (en) begin
        if (cp0_addr == c_ADDR_SR) begin
          sr_im_d  = cp0_din[15:10];
          sr_exl_d = cp0_din[1];
          sr_ie_d  = cp0_din[0];
        end else if (cp0_addr == c_ADDR_EPC) begin
          epc_d = cp0_din;
        end
      end
      if (eret) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // State registers; Cause.IP samples the interrupt lines on every edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= hw_int;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule
`default_nettype wire
